// File: rtl/router_pkg.sv
// Shared router constants: default widths, FIFO depth and header field bounds.
// The helper turns a header length field into the number of bytes still to come.
package router_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int FIFO_DEPTH   = 16;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;
  localparam int PKT_CNT_W    = 7;

  // Payload length plus the trailing parity byte.
  function automatic logic [PKT_CNT_W-1:0] pkt_len(
    input logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len
  );
    return {1'b0, len} + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-destination router FIFO: stores bytes tagged with their header flag and
// tracks the packet being read so data_out idles at zero between packets.
module router_fifo #(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
  parameter int DEPTH      = router_pkg::FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  read_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);
  import router_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef logic [DATA_WIDTH:0] entry_t;

  entry_t                mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PKT_CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  entry_t                rd_word;
  logic                  clear;
  logic                  do_wr;
  logic                  do_rd;

  // The MSB of each pointer is a wrap flag; it is what tells full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
  assign clear   = reset || soft_reset;
  assign do_wr   = write_enb && !full && !clear;
  assign do_rd   = read_enb && !empty && !clear;

  assign data_out = data_out_q;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;

    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (do_rd) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      data_out_d = rd_word[DATA_WIDTH-1:0];
      // A header always reloads, abandoning whatever was left of the last packet.
      if (rd_word[DATA_WIDTH]) begin
        pkt_cnt_d = pkt_len(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]);
      end else if (pkt_cnt_q != '0) begin
        pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
      end
    end else if (pkt_cnt_q == '0) begin
      data_out_d = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together.
  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers makes old entries unreachable.
  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios followed by random
// traffic, all compared against a queue-based packet model.
module tb_router_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          soft_reset = 1'b0;
  logic          write_enb = 1'b0;
  logic          read_enb = 1'b0;
  logic          lfd_state = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  router_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of {header flag, byte}, the bytes left in the
  // current packet, and the value data_out should show.
  logic [DW:0] model_q[$];
  int          model_cnt  = 0;
  logic [7:0]  model_dout = '0;

  int n_checks = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_edge(input logic rst, input logic sr, input logic we,
                            input logic re, input logic lfd, input logic [7:0] din);
    logic       can_rd;
    logic       can_wr;
    logic [8:0] e;
    if (rst || sr) begin
      model_q.delete();
      model_cnt  = 0;
      model_dout = '0;
    end else begin
      can_rd = re && (model_q.size() > 0);
      can_wr = we && (model_q.size() < DEPTH);
      if (can_rd) begin
        e          = model_q.pop_front();
        model_dout = e[7:0];
        if (e[8]) model_cnt = int'(e[7:2]) + 1;
        else if (model_cnt > 0) model_cnt--;
      end else if (model_cnt == 0) begin
        model_dout = '0;
      end
      if (can_wr) model_q.push_back({lfd, din});
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic sr, input logic we,
                      input logic re, input logic lfd, input logic [7:0] din);
    reset      = rst;
    soft_reset = sr;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    @(posedge clock);
    model_edge(rst, sr, we, re, lfd, din);
    #1;
    check({tag, " data_out"}, 32'(data_out), 32'(model_dout));
    check({tag, " full"},     32'(full),     32'(model_q.size() == DEPTH));
    check({tag, " empty"},    32'(empty),    32'(model_q.size() == 0));
  endtask

  task automatic wr(input string tag, input logic lfd, input logic [7:0] din);
    step(tag, 1'b0, 1'b0, 1'b1, 1'b0, lfd, din);
  endtask

  task automatic rd(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    // Reset state.
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step("reset", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA);
    check("reset empty const", 32'(empty), 32'd1);
    check("reset data_out const", 32'(data_out), 32'd0);

    // Read while empty does nothing.
    repeat (3) rd("rd_empty");

    // Header 0x0C: 3 payload bytes plus parity, then idle zero.
    wr("pkt_wr", 1'b1, 8'h0C);
    wr("pkt_wr", 1'b0, 8'h11);
    wr("pkt_wr", 1'b0, 8'h22);
    wr("pkt_wr", 1'b0, 8'h33);
    wr("pkt_wr", 1'b0, 8'h5E);
    rd("pkt_rd");
    check("pkt header out", 32'(data_out), 32'h0C);
    repeat (4) rd("pkt_rd");
    check("pkt parity out", 32'(data_out), 32'h5E);
    idle("pkt_idle");
    check("pkt idle zero", 32'(data_out), 32'h00);
    idle("pkt_idle");

    // Fill to full, overflow write dropped, drain.
    for (int i = 0; i < DEPTH; i++) wr("fill", 1'b0, 8'($urandom));
    check("fill full const", 32'(full), 32'd1);
    wr("overflow", 1'b0, 8'hEE);
    for (int i = 0; i < DEPTH; i++) rd("drain");
    check("drain empty const", 32'(empty), 32'd1);

    // Occupancy 15 with simultaneous traffic across pointer wrap.
    for (int i = 0; i < DEPTH - 1; i++) wr("occ15", 1'b0, 8'($urandom));
    for (int i = 0; i < 40; i++) step("rw15", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < DEPTH - 1; i++) rd("drain15");

    // Full with simultaneous read and write: read wins, write dropped.
    for (int i = 0; i < DEPTH; i++) wr("fill2", 1'b0, 8'($urandom));
    step("rw_full", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hDD);
    check("rw_full not full", 32'(full), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) rd("drain_full");

    // Soft reset with concurrent read and write.
    for (int i = 0; i < 6; i++) wr("pre_sr", 1'b0, 8'(8'h40 + i));
    step("soft_rst", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
    check("soft_rst data_out const", 32'(data_out), 32'd0);
    wr("post_sr", 1'b0, 8'h9A);
    rd("post_sr");
    check("post_sr byte", 32'(data_out), 32'h9A);
    idle("post_sr");

    // Random traffic, including headers, soft resets and resets.
    for (int i = 0; i < 500; i++) begin
      step("rand",
           ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 7) == 0),
           8'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, n_checks);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload byte width.
REQ-002 Parameter DEPTH, default 16, storage entries; power of two.
REQ-003 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port soft_reset  input  1  synchronous flush request from the sync stage (per-FIFO timeout).
REQ-006 Port write_enb  input  1  this FIFO's one-hot bit of the sync stage write_enb bus.
REQ-007 Port read_enb  input  1  destination read request.
REQ-008 Port lfd_state  input  1  high while data_in carries a header byte.
REQ-009 Port data_in  input  DATA_WIDTH  byte from the router register stage.
REQ-010 Port data_out  output  DATA_WIDTH  registered read data.
REQ-011 Port full  output  1  no free entry; feeds sync stage full_x.
REQ-012 Port empty  output  1  no stored entry; sync stage derives vld_out_x from it.

Function
REQ-013 Storage: DEPTH entries of DATA_WIDTH+1 bits; bit DATA_WIDTH holds lfd_state captured with the byte.
REQ-014 Pointers: wr_ptr, rd_ptr each log2(DEPTH)+1 bits; low bits address, MSB is wrap flag.
REQ-015 empty = (wr_ptr == rd_ptr); full = address bits equal and MSBs differ; both combinational from pointers.
REQ-016 Write: write_enb && !full -> store {lfd_state, data_in} at wr_ptr, wr_ptr+1 same edge.
REQ-017 Write while full -> dropped, no state change.
REQ-018 Read: read_enb && !empty -> data_out <= stored byte at next edge (1-cycle latency), rd_ptr+1.
REQ-019 Read while empty -> ignored; data_out holds value.
REQ-020 Simultaneous read and write, neither blocked -> both performed; occupancy unchanged.
REQ-021 Simultaneous read and write when full -> read performed, write dropped (full evaluated before edge).
REQ-022 Simultaneous read and write when empty -> write performed, read ignored.
REQ-023 Pointer increment wraps modulo 2*DEPTH; no saturation.
REQ-024 Packet counter pkt_cnt, 7 bits: on read of entry with header flag set, load data[7:2] + 1 (payload + parity).
REQ-025 On read of non-header entry with pkt_cnt != 0 -> pkt_cnt - 1.
REQ-026 When pkt_cnt == 0 and no read this cycle -> data_out <= 0 at next edge (packet boundary idle value).
REQ-027 Header read while pkt_cnt != 0 -> counter reloaded; prior packet remainder abandoned.

Reset
REQ-028 reset high at edge -> wr_ptr=0, rd_ptr=0, pkt_cnt=0, data_out=0; full=0, empty=1 thereafter.
REQ-029 soft_reset high at edge (reset low) -> same clearing as REQ-028; concurrent read/write that edge discarded.
REQ-030 Priority: reset > soft_reset > write/read.
REQ-031 Storage array contents not reset; unread entries unreachable after pointer clear.
REQ-032 Reset or soft_reset mid-packet -> packet lost, next write starts clean.

Structure
REQ-033 Shared package router_pkg holds DATA_WIDTH, FIFO_DEPTH, header length field bounds (7:2) and address field bounds (1:0).
REQ-034 Single module; no sub-module; three instances in router top, one per destination.

Verification
REQ-035 Reset, then write header 8'h0C (len 3, lfd=1) + 3 payload + parity, read 5 -> bytes in order, data_out 1 cycle after each read_enb, then 8'h00, empty=1.
REQ-036 Write 16 bytes no reads -> full=1 after 16th edge; 17th write dropped; 16 reads return first 16 bytes, empty=1.
REQ-037 Occupancy 15, write+read same cycle repeatedly 40 cycles -> full never set, order preserved across pointer wrap.
REQ-038 Full FIFO, write+read same cycle -> occupancy 15, full=0, dropped byte never appears.
REQ-039 Write 6 bytes, assert soft_reset one cycle with read_enb high -> empty=1, data_out=0, next write/read returns new byte only.
REQ-040 Read_enb while empty after reset -> data_out stays 0, rd_ptr unchanged.
